// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: the serial line coming in and the parallel
// byte, strobes and busy flag going out to the consumer.
interface uart_rx_if;
    logic       serial_data;
    logic [7:0] rx_parallel_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_error;

    // The receiver sources the byte stream.
    modport master (
        input  serial_data,
        output rx_parallel_data,
        output rx_valid,
        output busy,
        output frame_error
    );

    // The consumer (or a line driver in a bench) sits on the other side.
    modport slave (
        output serial_data,
        input  rx_parallel_data,
        input  rx_valid,
        input  busy,
        input  frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits MSB first, one stop bit.
// The line is synchronised into rx_clk, the start bit is qualified at its
// middle, and every later bit is sampled one full bit period apart.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 20,
    parameter int HALF_BIT       = (CLOCKS_PER_BIT - 1) / 2
) (
    input  logic       rx_clk,
    input  logic       rst,
    uart_rx_if.master  rx_if,
    output logic [2:0] rx_state,
    output logic [2:0] bit_index
);

    localparam logic [2:0] DATA_IDLE  = 3'd0;
    localparam logic [2:0] DATA_START = 3'd1;
    localparam logic [2:0] DATA_BIT   = 3'd2;
    localparam logic [2:0] DATA_STOP  = 3'd3;

    localparam logic [15:0] BIT_LAST  = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT);

    logic        sync1_reg;
    logic        rxs_reg;
    logic        rxs_prev_reg;
    logic [2:0]  state_reg,     state_next;
    logic [2:0]  bit_index_reg, bit_index_next;
    logic [15:0] clk_count_reg, clk_count_next;
    logic [7:0]  shift_reg,     shift_next;
    logic [7:0]  data_reg,      data_next;
    logic        valid_reg,     valid_next;
    logic        ferr_reg,      ferr_next;
    logic        bit_sample;
    logic        falling_edge;

    // Two-flop synchroniser plus a history flop; all idle-high after reset.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            sync1_reg    <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rx_if.serial_data;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    assign falling_edge = rxs_prev_reg & ~rxs_reg;
    assign bit_sample   = (state_reg == DATA_BIT) && (clk_count_reg == BIT_LAST);

    // Each shift bit only loads when its own index is the one being sampled.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (bit_sample && (bit_index_reg == 3'(gi)))
                                    ? rxs_reg : shift_reg[gi];
        end
    endgenerate

    // Frame sequencing: counters, state transitions and one-cycle strobes.
    always_comb begin
        state_next     = state_reg;
        bit_index_next = bit_index_reg;
        clk_count_next = clk_count_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        ferr_next      = 1'b0;
        case (state_reg)
            DATA_IDLE: begin
                clk_count_next = 16'd0;
                bit_index_next = 3'd7;
                // Only a fresh 1->0 transition starts a frame; a stuck-low
                // line stays idle.
                if (falling_edge) begin
                    state_next = DATA_START;
                end
            end
            DATA_START: begin
                if (clk_count_reg < HALF_LAST) begin
                    clk_count_next = clk_count_reg + 16'd1;
                end else begin
                    clk_count_next = 16'd0;
                    // Line back high at mid start bit means a glitch.
                    state_next     = rxs_reg ? DATA_IDLE : DATA_BIT;
                end
            end
            DATA_BIT: begin
                if (clk_count_reg < BIT_LAST) begin
                    clk_count_next = clk_count_reg + 16'd1;
                end else begin
                    clk_count_next = 16'd0;
                    if (bit_index_reg != 3'd0) begin
                        bit_index_next = bit_index_reg - 3'd1;
                    end else begin
                        bit_index_next = 3'd7;
                        state_next     = DATA_STOP;
                    end
                end
            end
            DATA_STOP: begin
                if (clk_count_reg < BIT_LAST) begin
                    clk_count_next = clk_count_reg + 16'd1;
                end else begin
                    clk_count_next = 16'd0;
                    state_next     = DATA_IDLE;
                    // A bad stop bit leaves the last good byte in place.
                    if (rxs_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = DATA_IDLE;
                clk_count_next = 16'd0;
                bit_index_next = 3'd7;
            end
        endcase
    end

    // Frame state registers; reset abandons any frame in flight.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_reg     <= DATA_IDLE;
            bit_index_reg <= 3'd7;
            clk_count_reg <= 16'd0;
            shift_reg     <= 8'd0;
            data_reg      <= 8'd0;
            valid_reg     <= 1'b0;
            ferr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_index_reg <= bit_index_next;
            clk_count_reg <= clk_count_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            ferr_reg      <= ferr_next;
        end
    end

    assign rx_if.rx_parallel_data = data_reg;
    assign rx_if.rx_valid         = valid_reg;
    assign rx_if.frame_error      = ferr_reg;
    assign rx_if.busy             = (state_reg != DATA_IDLE);
    assign rx_state               = state_reg;
    assign bit_index              = bit_index_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three receivers at 20, 4 and 16 clocks per
// bit share one clock and reset; each has its own serial line.
module tb_uart_rx;

    logic       rx_clk;
    logic       rst;
    logic [2:0] ser;
    int         cyc;
    int         checks;
    int         errors;

    uart_rx_if if0 ();
    uart_rx_if if1 ();
    uart_rx_if if2 ();

    logic [2:0] st0, st1, st2;
    logic [2:0] bi0, bi1, bi2;

    assign if0.serial_data = ser[0];
    assign if1.serial_data = ser[1];
    assign if2.serial_data = ser[2];

    uart_rx #(.CLOCKS_PER_BIT(20)) dut0 (.rx_clk(rx_clk), .rst(rst), .rx_if(if0), .rx_state(st0), .bit_index(bi0));
    uart_rx #(.CLOCKS_PER_BIT(4))  dut1 (.rx_clk(rx_clk), .rst(rst), .rx_if(if1), .rx_state(st1), .bit_index(bi1));
    uart_rx #(.CLOCKS_PER_BIT(16)) dut2 (.rx_clk(rx_clk), .rst(rst), .rx_if(if2), .rx_state(st2), .bit_index(bi2));

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    // Strobe and busy monitor, sampled on the falling edge.
    logic [2:0] vld, fe;
    logic [7:0] pdata [3];
    int         v_count [3];
    int         e_count [3];
    int         v_cyc [3];
    int         e_cyc [3];
    logic [7:0] v_data [3];
    logic [7:0] hist_data [16];
    int         hist_cyc [16];
    int         both_count;
    int         busy_rise;
    int         busy_fall;
    logic       busy_prev;

    assign vld = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
    assign fe  = {if2.frame_error, if1.frame_error, if0.frame_error};
    assign pdata[0] = if0.rx_parallel_data;
    assign pdata[1] = if1.rx_parallel_data;
    assign pdata[2] = if2.rx_parallel_data;

    initial begin
        cyc = 0; both_count = 0; busy_rise = -1; busy_fall = -1; busy_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v_count[i] = 0; e_count[i] = 0; v_cyc[i] = -1; e_cyc[i] = -1; v_data[i] = 8'h00;
        end
    end

    always @(negedge rx_clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            if (vld[ch]) begin
                v_count[ch] <= v_count[ch] + 1;
                v_cyc[ch]   <= cyc;
                v_data[ch]  <= pdata[ch];
                if (ch == 0 && v_count[0] < 16) begin
                    hist_data[v_count[0]] <= pdata[0];
                    hist_cyc[v_count[0]]  <= cyc;
                end
            end
            if (fe[ch]) begin
                e_count[ch] <= e_count[ch] + 1;
                e_cyc[ch]   <= cyc;
            end
            if (vld[ch] && fe[ch]) both_count <= both_count + 1;
        end
        if (if0.busy && !busy_prev) busy_rise <= cyc;
        if (!if0.busy && busy_prev) busy_fall <= cyc;
        busy_prev <= if0.busy;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    // Drives a whole frame starting in the current cycle; returns exactly
    // 10 bit periods later so consecutive calls have no idle gap.
    task automatic send_byte(input int ch, input logic [7:0] b, input logic stop_bit,
                             input int cpb, output int d);
        ser[ch] = 1'b0;
        d = cyc;
        for (int k = 7; k >= 0; k--) begin
            wait_cycles(cpb);
            ser[ch] = b[k];
        end
        wait_cycles(cpb);
        ser[ch] = stop_bit;
        wait_cycles(cpb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ser = 3'b111;
        wait_cycles(3);
        checks++; if (st0 !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st0); end
        checks++; if (bi0 !== 3'd7) begin errors++; $display("FAIL reset_bit_index got %0d exp 7", bi0); end
        checks++; if (if0.rx_parallel_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", if0.rx_parallel_data); end
        checks++; if (if0.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if0.rx_valid); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
        checks++; if (if0.frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", if0.frame_error); end
        rst = 1'b0;
        wait_cycles(5);
        $display("test_reset done");
    endtask

    task automatic test_single();
        int d, vb, eb;
        vb = v_count[0]; eb = e_count[0];
        send_byte(0, 8'hA5, 1'b1, 20, d);
        wait_cycles(20);
        checks++; if (v_count[0] - vb !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", v_count[0] - vb); end
        checks++; if (v_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %02h exp a5", v_data[0]); end
        checks++; if (v_cyc[0] - d !== 193) begin errors++; $display("FAIL single_latency got %0d exp 193", v_cyc[0] - d); end
        checks++; if (e_count[0] - eb !== 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", e_count[0] - eb); end
        checks++; if (busy_rise - d !== 3) begin errors++; $display("FAIL single_busy_rise got %0d exp 3", busy_rise - d); end
        checks++; if (busy_fall - d !== 193) begin errors++; $display("FAIL single_busy_fall got %0d exp 193", busy_fall - d); end
        $display("test_single byte a5 latency %0d", v_cyc[0] - d);
    endtask

    task automatic test_back_to_back();
        int d, dd, vb;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        vb = v_count[0];
        send_byte(0, exp_b[0], 1'b1, 20, d);
        send_byte(0, exp_b[1], 1'b1, 20, dd);
        send_byte(0, exp_b[2], 1'b1, 20, dd);
        wait_cycles(20);
        checks++; if (v_count[0] - vb !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", v_count[0] - vb); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (hist_data[vb + i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got %02h exp %02h", i, hist_data[vb + i], exp_b[i]); end
            checks++; if (hist_cyc[vb + i] - d !== 193 + 200 * i) begin errors++; $display("FAIL b2b_time%0d got %0d exp %0d", i, hist_cyc[vb + i] - d, 193 + 200 * i); end
            $display("test_back_to_back frame %0d data %02h", i, hist_data[vb + i]);
        end
    endtask

    task automatic test_glitch();
        int d, vb, eb;
        vb = v_count[0]; eb = e_count[0];
        ser[0] = 1'b0;
        d = cyc;
        wait_cycles(5);
        ser[0] = 1'b1;
        checks++; if (st0 !== 3'd1) begin errors++; $display("FAIL glitch_start got %0d exp 1", st0); end
        while (cyc < d + 12) wait_cycles(1);
        checks++; if (st0 !== 3'd1) begin errors++; $display("FAIL glitch_check_cycle got %0d exp 1", st0); end
        wait_cycles(1);
        checks++; if (st0 !== 3'd0) begin errors++; $display("FAIL glitch_idle got %0d exp 0", st0); end
        wait_cycles(200);
        checks++; if ((v_count[0] - vb) + (e_count[0] - eb) !== 0) begin errors++; $display("FAIL glitch_strobes got %0d exp 0", (v_count[0] - vb) + (e_count[0] - eb)); end
        $display("test_glitch returned to idle");
    endtask

    task automatic test_frame_error();
        int d, vb, eb;
        vb = v_count[0]; eb = e_count[0];
        send_byte(0, 8'h81, 1'b0, 20, d);
        wait_cycles(500);
        checks++; if (e_count[0] - eb !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", e_count[0] - eb); end
        checks++; if (e_cyc[0] - d !== 193) begin errors++; $display("FAIL ferr_time got %0d exp 193", e_cyc[0] - d); end
        checks++; if (v_count[0] - vb !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", v_count[0] - vb); end
        checks++; if (if0.rx_parallel_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %02h exp 3c", if0.rx_parallel_data); end
        checks++; if (st0 !== 3'd0 || if0.busy !== 1'b0) begin errors++; $display("FAIL ferr_low_idle got state %0d busy %b exp 0 0", st0, if0.busy); end
        checks++; if (busy_rise - d !== 3) begin errors++; $display("FAIL ferr_no_retrigger got %0d exp 3", busy_rise - d); end
        ser[0] = 1'b1;
        wait_cycles(20);
        checks++; if (st0 !== 3'd0) begin errors++; $display("FAIL ferr_rise_idle got %0d exp 0", st0); end
        $display("test_frame_error errors seen %0d", e_count[0] - eb);
    endtask

    task automatic test_reset_mid();
        int d, vb, eb;
        logic [7:0] b;
        b = 8'h5A;
        vb = v_count[0]; eb = e_count[0];
        ser[0] = 1'b0;
        d = cyc;
        for (int k = 7; k >= 4; k--) begin
            wait_cycles(20);
            ser[0] = b[k];
        end
        while (cyc < d + 90) wait_cycles(1);
        checks++; if (bi0 !== 3'd4) begin errors++; $display("FAIL mid_bit_index got %0d exp 4", bi0); end
        rst = 1'b1;
        wait_cycles(1);
        checks++; if (st0 !== 3'd0 || if0.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got state %0d busy %b exp 0 0", st0, if0.busy); end
        checks++; if (if0.rx_parallel_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %02h exp 00", if0.rx_parallel_data); end
        rst = 1'b0;
        ser[0] = 1'b1;
        wait_cycles(200);
        checks++; if ((v_count[0] - vb) + (e_count[0] - eb) !== 0) begin errors++; $display("FAIL mid_no_strobe got %0d exp 0", (v_count[0] - vb) + (e_count[0] - eb)); end
        send_byte(0, 8'h5A, 1'b1, 20, d);
        wait_cycles(20);
        checks++; if (v_count[0] - vb !== 1 || v_data[0] !== 8'h5A) begin errors++; $display("FAIL mid_next_frame got count %0d data %02h exp 1 5a", v_count[0] - vb, v_data[0]); end
        checks++; if (v_cyc[0] - d !== 193) begin errors++; $display("FAIL mid_next_latency got %0d exp 193", v_cyc[0] - d); end
        $display("test_reset_mid next frame data %02h", v_data[0]);
    endtask

    task automatic test_param_sweep();
        int d, vb;
        vb = v_count[1];
        send_byte(1, 8'hC3, 1'b1, 4, d);
        wait_cycles(10);
        checks++; if (v_count[1] - vb !== 1 || v_data[1] !== 8'hC3) begin errors++; $display("FAIL cpb4_data got count %0d data %02h exp 1 c3", v_count[1] - vb, v_data[1]); end
        checks++; if (v_cyc[1] - d !== 41) begin errors++; $display("FAIL cpb4_latency got %0d exp 41", v_cyc[1] - d); end
        $display("test_param_sweep cpb 4 data %02h latency %0d", v_data[1], v_cyc[1] - d);
        vb = v_count[2];
        send_byte(2, 8'hC3, 1'b1, 16, d);
        wait_cycles(20);
        checks++; if (v_count[2] - vb !== 1 || v_data[2] !== 8'hC3) begin errors++; $display("FAIL cpb16_data got count %0d data %02h exp 1 c3", v_count[2] - vb, v_data[2]); end
        checks++; if (v_cyc[2] - d !== 155) begin errors++; $display("FAIL cpb16_latency got %0d exp 155", v_cyc[2] - d); end
        $display("test_param_sweep cpb 16 data %02h latency %0d", v_data[2], v_cyc[2] - d);
        checks++; if (both_count !== 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", both_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ser = 3'b111;
        @(posedge rx_clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
